// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receiver.
//   state_e       receiver FSM state encoding
//   DATA_BITS     payload bits per frame
//   parity_ok()   odd-parity check over payload plus parity bit
package ps2_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    // Odd parity: the payload bits and the parity bit together hold an odd number of ones.
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] payload, input logic par);
        return ^{payload, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer followed by a level filter for one PS/2 line.
//   clk       system clock
//   reset     synchronous, active-high
//   line_in   asynchronous line input (idles high)
//   line_out  filtered level; resets to 1
// The filtered level follows the synchronized level only after it has differed
// for FILTER consecutive cycles, so shorter glitches are ignored.
module ps2_line_filter #(
    parameter int FILTER = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_out
);

    localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_out = filt_q;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver with valid/ready byte output.
//   clk         system clock
//   reset       synchronous, active-high
//   ps2_clk     asynchronous PS/2 clock line
//   ps2_dat     asynchronous PS/2 data line
//   data        received byte, stable while valid=1
//   valid       data holds an unconsumed byte
//   ready       consumer accepts data when valid & ready
//   parity_err  one-cycle pulse, frame dropped on parity mismatch
//   frame_err   one-cycle pulse, frame dropped on bad stop bit or timeout
//   overrun     one-cycle pulse, good frame dropped because data was still held
//
// state  | meaning
// IDLE   | waiting for a falling edge with data low (start bit)
// DATA   | shifting in payload bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit and delivering the byte
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BW = $clog2(DATA_BITS);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic clk_f, dat_f;

    ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
        .clk      (clk),
        .reset    (reset),
        .line_in  (ps2_clk),
        .line_out (clk_f)
    );

    ps2_line_filter #(.FILTER(FILTER)) u_dat_filter (
        .clk      (clk),
        .reset    (reset),
        .line_in  (ps2_dat),
        .line_out (dat_f)
    );

    state_e               state_q, state_d;
    logic                 clk_prev_q;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 fall;
    logic                 timeout;

    assign fall = clk_prev_q & ~clk_f;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = '0;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (!fall && state_q != IDLE) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        // A fall on the same cycle always takes priority over the timeout.
        timeout = !fall && (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if (fall && !dat_f) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d = {dat_f, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_f;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (!dat_f) begin
                        ferr_d = 1'b1;
                    end else if (!parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d  = IDLE;
            ferr_d   = 1'b1;
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_prev_q <= clk_f;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
